// File: rtl/sw_ctrl_pkg.sv
// Shared stopwatch-control definitions: state encoding and button conditioning constants.
package sw_ctrl_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_STOP = 2'd2;
  localparam logic [1:0] STATE_LAP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_RUN  = STATE_RUN,
    ST_STOP = STATE_STOP,
    ST_LAP  = STATE_LAP
  } state_e;

  // Buttons are active-low, so the released level is 1.
  localparam logic BTN_RELEASED = 1'b1;
  localparam int   DEB_CNT_W    = 24;

endpackage

// File: rtl/button_conditioner.sv
// One pushbutton path: 2-FF synchronizer, debouncer and single-cycle press pulse.
module button_conditioner
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_press
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           r_sync;
  logic [1:0]           r_vld;
  logic                 r_level;
  logic [DEB_CNT_W-1:0] r_cnt;
  logic                 r_armed;
  logic                 r_press;

  logic w_sample;
  logic w_differs;
  logic w_accept;

  assign w_sample  = r_sync[1];
  assign w_differs = (w_sample != r_level);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  // r_armed stays low until a real released sample is seen after reset, so a
  // button held through reset must be released before it can produce a press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_vld   <= 2'b00;
      r_level <= BTN_RELEASED;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn_n};
      r_vld  <= {r_vld[0], 1'b1};
      if (!w_differs || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_level <= w_sample;
      end
      if (r_vld[1] && (w_sample == BTN_RELEASED)) begin
        r_armed <= 1'b1;
      end
      r_press <= w_accept && (w_sample != BTN_RELEASED) && r_armed;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control FSM (IDLE/RUN/STOP/LAP) with debounced buttons and registered outputs.
// Define SW_CTRL_LAP_EN to enable the LAP state and display_hold.
module stopwatch_control
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic       tick_100hz,
  input  logic       start_stop_btn,
  input  logic       lap_btn,
  input  logic       clear_btn,
  input  logic       overflow,
  output logic       count_en,
  output logic       count_clr,
  output logic       display_hold,
  output logic [1:0] state_o
);

  logic w_ss_press;
  logic w_clr_press;
  logic w_lap_press;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
    .i_clk(CLK_50), .i_rst(reset), .i_btn_n(start_stop_btn), .o_press(w_ss_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .i_clk(CLK_50), .i_rst(reset), .i_btn_n(clear_btn), .o_press(w_clr_press)
  );

`ifdef SW_CTRL_LAP_EN
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .i_clk(CLK_50), .i_rst(reset), .i_btn_n(lap_btn), .o_press(w_lap_press)
  );
`else
  logic w_unused_lap_btn;
  assign w_unused_lap_btn = lap_btn;
  assign w_lap_press      = 1'b0;
`endif

  state_e r_state;
  state_e w_next;
  logic   r_count_en;
  logic   r_count_clr;
  logic   w_ss;
  logic   w_clr;
  logic   w_lap;
  logic   w_en;
  logic   w_do_clr;

  // Priority start_stop > clear > lap; losers in the same cycle are dropped.
  assign w_ss  = w_ss_press;
  assign w_clr = w_clr_press && !w_ss_press;
  assign w_lap = w_lap_press && !w_ss_press && !w_clr_press;

  always_comb begin
    w_next   = r_state;
    w_do_clr = 1'b0;
    w_en     = tick_100hz && !overflow && ((r_state == ST_RUN) || (r_state == ST_LAP));
    case (r_state)
      ST_IDLE: begin
        if (w_ss) begin
          w_next = ST_RUN;
        end else if (w_clr) begin
          w_do_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (overflow || w_ss) begin
          w_next = ST_STOP;
        end else if (w_lap) begin
          w_next = ST_LAP;
        end
      end
      ST_LAP: begin
        if (overflow || w_ss) begin
          w_next = ST_STOP;
        end else if (w_lap) begin
          w_next = ST_RUN;
        end
      end
      ST_STOP: begin
        if (w_ss) begin
          w_next = ST_RUN;
        end else if (w_clr) begin
          w_next   = ST_IDLE;
          w_do_clr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_count_en  <= 1'b0;
      r_count_clr <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_count_en  <= w_en;
      r_count_clr <= w_do_clr;
    end
  end

`ifdef SW_CTRL_LAP_EN
  // Registered from the next state so it drops together with leaving LAP.
  logic r_hold;
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_hold <= 1'b0;
    end else begin
      r_hold <= (w_next == ST_LAP);
    end
  end
  assign display_hold = r_hold;
`else
  assign display_hold = 1'b0;
`endif

  assign count_en  = r_count_en;
  assign count_clr = r_count_clr;
  assign state_o   = r_state;

endmodule

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz); consecutive stable cycles required to accept a button level; legal range 2 to 2^24-1.
- REQ-002: CLK_50  in  1  system clock, 50 MHz; single clock domain.
- REQ-003: reset  in  1  asynchronous, active-high reset.
- REQ-004: tick_100hz  in  1  one-cycle pulse every 10 ms from the clock divider, synchronous to CLK_50.
- REQ-005: start_stop_btn  in  1  raw pushbutton, active-low (0 = pressed), asynchronous and bouncing.
- REQ-006: lap_btn  in  1  raw pushbutton, active-low.
- REQ-007: clear_btn  in  1  raw pushbutton, active-low.
- REQ-008: overflow  in  1  active-high; counter has reached 59:59.99.
- REQ-009: count_en  out  1  one-cycle pulse; counter advances 0.01 s.
- REQ-010: count_clr  out  1  one-cycle pulse; counter clears to 00:00.00.
- REQ-011: display_hold  out  1  level; seven-seg encoder freezes its displayed value while high.
- REQ-012: state_o  out  2  current state encoding: IDLE=0, RUN=1, STOP=2, LAP=3.

Function
- REQ-013: Each button path: 2-FF synchronizer, then a debounce counter that reloads on any level change; the new level is accepted after DEBOUNCE_CYCLES consecutive identical cycles.
- REQ-014: Press = accepted released-to-pressed transition; a one-cycle press pulse fires on the cycle after acceptance; release produces no pulse; a held button produces exactly one pulse.
- REQ-015: FSM states IDLE, RUN, STOP, LAP; all outputs registered.
- REQ-016: IDLE: start_stop -> RUN; clear -> stay IDLE and pulse count_clr.
- REQ-017: RUN: start_stop -> STOP; lap -> LAP; overflow -> STOP; clear ignored.
- REQ-018: LAP: lap -> RUN; start_stop -> STOP; overflow -> STOP; clear ignored.
- REQ-019: STOP: start_stop -> RUN; clear -> IDLE and pulse count_clr; lap ignored.
- REQ-020: Simultaneous press pulses: priority start_stop > clear > lap; lower-priority pulses in that cycle are discarded.
- REQ-021: count_en asserts exactly one cycle after a tick_100hz pulse when, in the tick cycle, state is RUN or LAP and overflow is 0.
- REQ-022: A tick in the same cycle as a transition out of RUN/LAP still produces count_en; a tick in the same cycle as a transition into RUN does not.
- REQ-023: display_hold = 1 iff state is LAP; it falls in the same cycle state_o leaves LAP.
- REQ-024: count_clr and count_en never assert in the same cycle.

Reset
- REQ-025: While reset is high: state IDLE, count_en=0, count_clr=0, display_hold=0, state_o=0, debounced levels=released, debounce counters=0, synchronizer flops=1.
- REQ-026: Reset asserted mid-debounce or mid-operation discards pending presses; no press pulse is generated from a button held through reset deassertion until it is released and pressed again.

Configuration
- REQ-027: Macro SW_CTRL_LAP_EN defined: LAP state and display_hold behave as above.
- REQ-028: Macro not defined: lap_btn port is retained but ignored, its debouncer is not instantiated, LAP is unreachable, display_hold is tied 0, and state_o never equals 3.

Structure
- REQ-029: Shared package sw_ctrl_pkg holds the state enum (2-bit) and the state encoding constants.
- REQ-030: One sub-module, button_conditioner (synchronizer, debouncer, press pulse), instantiated per button.

Verification (DEBOUNCE_CYCLES=4)
- REQ-031: Reset, then press start_stop for 10 cycles -> one press pulse; state_o 0->1; count_en follows each tick_100hz by 1 cycle.
- REQ-032: start_stop toggling every 2 cycles for 20 cycles, then stable pressed -> exactly one press pulse, 1 cycle after 4 stable cycles.
- REQ-033: RUN; press lap -> state 3, display_hold=1, count_en continues; press lap again -> state 1, display_hold=0.
- REQ-034: RUN with overflow=1 and a tick in the same cycle -> no count_en; state 2 next cycle.
- REQ-035: STOP; start_stop and clear pressed in the same cycle -> state 1, no count_clr; later STOP + clear alone -> one count_clr pulse, state 0.
- REQ-036: Build without SW_CTRL_LAP_EN; press lap in RUN -> state stays 1, display_hold stays 0.
